// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: op codes, FSM state encoding and op classification.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_ADD2 = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that use the carry chain (SLT is a subtract underneath).
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADD2) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice_n.sv
// Combinational SLICE-bit ALU slice: ripple adder plus bitwise logic ops.
module alu_slice_n
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             binvert,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             msb_cin
);

  logic [SLICE-1:0] bb;
  logic [SLICE-1:0] sum;
  logic [SLICE:0]   c;

  assign bb = binvert ? ~b : b;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ bb[i] ^ c[i];
      c[i + 1] = (a[i] & bb[i]) | (a[i] & c[i]) | (bb[i] & c[i]);
    end
  end

  assign cout    = c[SLICE];
  assign msb_cin = c[SLICE-1];

  always_comb begin
    y = sum;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      default: y = sum;
    endcase
  end

endmodule

// File: rtl/alu_serial_n.sv
// Multi-cycle WIDTH-bit ALU processing SLICE bits per cycle, LSB first, valid/ready on both sides.
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero flag output.
module alu_serial_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
`ifdef ALU_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic [SLICE-1:0] y;
  logic             s_cout, s_msb_cin, ovf_raw, addsub;

  alu_slice_n #(.SLICE(SLICE)) u_slice (
    .a       (a_q[SLICE-1:0]),
    .b       (b_q[SLICE-1:0]),
    .binvert (is_sub(op_q)),
    .cin     (carry_q),
    .op      (op_q),
    .y       (y),
    .cout    (s_cout),
    .msb_cin (s_msb_cin)
  );

  assign ovf_raw = s_msb_cin ^ s_cout;
  assign addsub  = is_arith(op_q) && (op_q != OP_SLT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef ALU_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = is_sub(op);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Operands shift down so the slice always sees bit 0; result fills from the top.
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = s_cout;
        res_d   = (res_q >> SLICE) | (WIDTH'(y) << (WIDTH - SLICE));
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cout_d  = addsub & s_cout;
          ovf_d   = addsub & ovf_raw;
          if (op_q == OP_SLT) res_d = WIDTH'(y[SLICE-1] ^ ovf_raw);
`ifdef ALU_ZERO_FLAG_EN
          zero_d  = (res_d == '0);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef ALU_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    op_q    <= op_d;
    carry_q <= carry_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
`ifdef ALU_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_n.sv
// Directed self-checking bench for alu_serial_n (WIDTH=32, SLICE=4).
module tb_alu_serial_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  op;
  logic        carry_out, overflow;
`ifdef ALU_ZERO_FLAG_EN
  logic        zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial_n #(.WIDTH(32), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait for out_valid; leaves the result pending in DONE.
  task automatic start_and_wait(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top,
                                output int lat);
    a        = ta;
    b        = tb_;
    op       = top;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [2:0] top, input logic [31:0] exp_res,
                        input logic exp_c, input logic exp_v);
    int lat;
    start_and_wait(ta, tb_, top, lat);
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " result"}, result, exp_res);
    check({tag, " carry"}, 32'(carry_out), 32'(exp_c));
    check({tag, " ovf"}, 32'(overflow), 32'(exp_v));
    release_out();
    check({tag, " idle"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", {30'd0, carry_out, overflow}, 32'd0);
`ifdef ALU_ZERO_FLAG_EN
    check("rst zero", 32'(zero), 32'd0);
`endif

    run_op("add ovf",  32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1);
    run_op("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add alt",  32'd3,         32'd4,         3'b101, 32'd7,         1'b0, 1'b0);
    run_op("sub neg",  32'd5,         32'd7,         3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("slt ovf",  32'h8000_0000, 32'h0000_0001, 3'b111, 32'd1,         1'b0, 1'b0);
    run_op("slt ge",   32'h0000_0001, 32'h8000_0000, 3'b111, 32'd0,         1'b0, 1'b0);
    run_op("slt lt",   32'hFFFF_FFFB, 32'd2,         3'b111, 32'd1,         1'b0, 1'b0);
    run_op("nor",      32'h0F0F_0000, 32'h00F0_000F, 3'b100, 32'hF000_FFF0, 1'b0, 1'b0);
    run_op("nand",     32'hFFFF_FFFF, 32'hFFFF_0000, 3'b011, 32'h0000_FFFF, 1'b0, 1'b0);
    run_op("and",      32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0);
    run_op("or",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0);

`ifdef ALU_ZERO_FLAG_EN
    start_and_wait(32'd9, 32'd9, 3'b110, lat);
    check("sub 9-9 result", result, 32'd0);
    check("sub 9-9 zero", 32'(zero), 32'd1);
    release_out();
    start_and_wait(32'd1, 32'd1, 3'b010, lat);
    check("add 1+1 result", result, 32'd2);
    check("add 1+1 zero", 32'(zero), 32'd0);
    release_out();
`endif

    // Backpressure, with a competing request that must be ignored while busy.
    start_and_wait(32'd100, 32'd23, 3'b010, lat);
    check("bp latency", 32'(lat), 32'd8);
    a = 32'd1; b = 32'd1; op = 3'b010; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp result", result, 32'd123);
    check("bp out_valid", 32'(out_valid), 32'd1);
    check("bp in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);

    // out_ready while idle must not disturb anything.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle out_ready", {30'd0, in_ready, out_valid}, 32'h2);

    // Reset during RUN cycle 3 aborts the op.
    a = 32'h1111_1111; b = 32'h2222_2222; op = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", result, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort no output", 32'(out_valid), 32'd0);
    run_op("add after rst", 32'd2, 32'd3, 3'b010, 32'd5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
